wino_in_tf_stream: RTL and testbench

WINO_IN_TF_STREAM -- requirements
Module: wino_in_tf_stream

---
 rtl/wino_in_tf_stream_if.sv | 27 ++
 rtl/wino_in_tf_stream.sv | 223 ++++++++++++++++++++++
 tb/tb_wino_in_tf_stream.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wino_in_tf_stream_if.sv
// wino_in_tf_stream_if: column-stream bus of the Winograd input transform.
// The input channel carries 4 lanes of DATA_W bits, and the output channel
// carries 4 lanes of DATA_W+2 bits plus an end-of-tile marker.
// master = producer/consumer side (testbench), slave = transform block.
interface wino_in_tf_stream_if #(
  parameter int DATA_W = 32
);
  localparam int OUT_W = DATA_W + 2;

  logic                 in_valid;
  logic                 in_ready;
  logic [4*DATA_W-1:0]  in_col;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*OUT_W-1:0]   out_col;
  logic                 out_last;

  modport master (
    output in_valid, in_col, out_ready,
    input  in_ready, out_valid, out_col, out_last
  );

  modport slave (
    input  in_valid, in_col, out_ready,
    output in_ready, out_valid, out_col, out_last
  );
endinterface

// File: rtl/wino_in_tf_stream.sv
// wino_in_tf_stream: streaming Winograd F(2,3) input transform V = B^T d B
// on 4x4 signed tiles. Columns arrive in order j=0..3 and are transformed
// by B^T on entry. The tile is held in one of two ping-pong banks, and
// columns k=0..3 of V are produced from the full bank as the consumer takes
// them.
// Build macro WINO_IN_TF_SAT_EN: clip every output lane to the signed DATA_W
// range and record any clip of a delivered column in the sticky sat_flag.
module wino_in_tf_stream #(
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  wino_in_tf_stream_if.slave bus,
  output logic               sat_flag
);
  localparam int OUT_W = DATA_W + 2;
  localparam int T_W   = DATA_W + 1;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_st_e;

  bank_st_e bank_st_q [2];
  bank_st_e bank_st_d [2];
  logic [1:0] wr_j_q, wr_j_d;
  logic       wr_bank_q, wr_bank_d;
  logic [1:0] rd_k_q, rd_k_d;
  logic       rd_bank_q, rd_bank_d;

  // Tile storage after the row transform: [bank][column j][row i]
  logic signed [T_W-1:0] t_q [2][4][4];

  logic                    acc_s;
  logic                    pop_s;
  logic                    in_ready_s;
  logic                    out_valid_s;
  logic signed [DATA_W-1:0] d_s     [4];
  logic signed [T_W-1:0]   t_col_s  [4];
  logic signed [OUT_W-1:0] ext_s    [4][4];
  logic signed [OUT_W-1:0] v_full_s [4];
  logic signed [OUT_W-1:0] v_lane_s [4];
  logic [4*OUT_W-1:0]      out_col_s;

  // The write bank can only be full while the reader still owns it; the
  // two banks are never both written and freed in the same cycle.
  assign in_ready_s  = (bank_st_q[wr_bank_q] != BANK_FULL);
  assign out_valid_s = (bank_st_q[rd_bank_q] == BANK_FULL);
  assign acc_s       = bus.in_valid && in_ready_s;
  assign pop_s       = out_valid_s && bus.out_ready;

  // Row transform of the incoming column: t = B^T d[:,j]
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      d_s[i] = bus.in_col[i*DATA_W +: DATA_W];
    end
    t_col_s[0] = T_W'(d_s[0]) - T_W'(d_s[2]);
    t_col_s[1] = T_W'(d_s[1]) + T_W'(d_s[2]);
    t_col_s[2] = T_W'(d_s[2]) - T_W'(d_s[1]);
    t_col_s[3] = T_W'(d_s[1]) - T_W'(d_s[3]);
  end

  // Capture the transformed column into the current write bank
  always_ff @(posedge clk) begin
    if (acc_s) begin
      for (int i = 0; i < 4; i++) begin
        t_q[wr_bank_q][wr_j_q][i] <= t_col_s[i];
      end
    end
  end

  // Bank state / pointer next-state: write side fills, read side drains
  always_comb begin
    bank_st_d[0] = bank_st_q[0];
    bank_st_d[1] = bank_st_q[1];
    wr_j_d       = wr_j_q;
    wr_bank_d    = wr_bank_q;
    rd_k_d       = rd_k_q;
    rd_bank_d    = rd_bank_q;
    if (acc_s) begin
      wr_j_d = wr_j_q + 2'd1;
      if (wr_j_q == 2'd3) begin
        bank_st_d[wr_bank_q] = BANK_FULL;
        wr_bank_d            = !wr_bank_q;
      end else begin
        bank_st_d[wr_bank_q] = BANK_FILLING;
      end
    end else begin
      wr_j_d = wr_j_q;
    end
    if (pop_s) begin
      rd_k_d = rd_k_q + 2'd1;
      if (rd_k_q == 2'd3) begin
        bank_st_d[rd_bank_q] = BANK_EMPTY;
        rd_bank_d            = !rd_bank_q;
      end else begin
        rd_bank_d = rd_bank_q;
      end
    end else begin
      rd_k_d = rd_k_q;
    end
  end

  // Bank state / pointer registers; reset drops any partial or unread tile
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st_q[0] <= BANK_EMPTY;
      bank_st_q[1] <= BANK_EMPTY;
      wr_j_q       <= 2'd0;
      wr_bank_q    <= 1'b0;
      rd_k_q       <= 2'd0;
      rd_bank_q    <= 1'b0;
    end else begin
      bank_st_q[0] <= bank_st_d[0];
      bank_st_q[1] <= bank_st_d[1];
      wr_j_q       <= wr_j_d;
      wr_bank_q    <= wr_bank_d;
      rd_k_q       <= rd_k_d;
      rd_bank_q    <= rd_bank_d;
    end
  end

  // Column transform of the read bank: V[:,k] = t B, at OUT_W bits
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        ext_s[j][i] = OUT_W'(t_q[rd_bank_q][j][i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      case (rd_k_q)
        2'd0:    v_full_s[i] = ext_s[0][i] - ext_s[2][i];
        2'd1:    v_full_s[i] = ext_s[1][i] + ext_s[2][i];
        2'd2:    v_full_s[i] = ext_s[2][i] - ext_s[1][i];
        2'd3:    v_full_s[i] = ext_s[1][i] - ext_s[3][i];
        default: v_full_s[i] = '0;
      endcase
    end
  end

`ifdef WINO_IN_TF_SAT_EN
  logic [3:0] clip_s;
  logic       sat_flag_q;
  logic       sat_flag_d;

  function automatic logic lane_clips(input logic signed [OUT_W-1:0] v);
    logic signed [OUT_W-1:0] hi;
    logic signed [OUT_W-1:0] lo;
    hi = {3'b000, {(DATA_W-1){1'b1}}};
    lo = {3'b111, {(DATA_W-1){1'b0}}};
    return (v > hi) || (v < lo);
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_lane(input logic signed [OUT_W-1:0] v);
    logic signed [OUT_W-1:0] hi;
    logic signed [OUT_W-1:0] lo;
    hi = {3'b000, {(DATA_W-1){1'b1}}};
    lo = {3'b111, {(DATA_W-1){1'b0}}};
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

  // Clip each lane to the signed DATA_W range, sign-extended to OUT_W
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      clip_s[i]   = lane_clips(v_full_s[i]);
      v_lane_s[i] = sat_lane(v_full_s[i]);
    end
  end

  // Sticky flag picks up clipping only on columns actually delivered
  always_comb begin
    if (pop_s && (clip_s != 4'd0)) begin
      sat_flag_d = 1'b1;
    end else begin
      sat_flag_d = sat_flag_q;
    end
  end

  // Sticky saturation flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag_q <= 1'b0;
    end else begin
      sat_flag_q <= sat_flag_d;
    end
  end

  assign sat_flag = sat_flag_q;
`else
  // Full-precision lanes pass straight through
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      v_lane_s[i] = v_full_s[i];
    end
  end

  assign sat_flag = 1'b0;
`endif

  // Drive the output column, forced to zero whenever nothing is valid
  always_comb begin
    out_col_s = '0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid_s) begin
        out_col_s[i*OUT_W +: OUT_W] = v_lane_s[i];
      end else begin
        out_col_s[i*OUT_W +: OUT_W] = '0;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_col   = out_col_s;
  assign bus.out_last  = out_valid_s && (rd_k_q == 2'd3);
endmodule

// File: tb/tb_wino_in_tf_stream.sv
// tb_wino_in_tf_stream: directed table vectors with hand-computed results,
// backpressure / throughput / mid-tile reset sequences, and a randomized
// stream checked against a direct B^T d B matrix-product model.
module tb_wino_in_tf_stream;
  localparam int DW = 8;
  localparam int OW = DW + 2;

  typedef logic [15:0][DW-1:0] tile_t;   // element [row*4 + col]
  typedef struct packed {
    tile_t               d;
    logic [15:0][OW-1:0] v;               // element [row*4 + k]
    logic                sat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic sat_flag;

  wino_in_tf_stream_if #(.DATA_W(DW)) bus ();

  wino_in_tf_stream #(.DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int bt [16];
  vec_t vecs [3];

  tile_t src_q [$];
  tile_t exp_q [$];
  int    wcol;
  int    rk;
  int    acc_cnt;
  bit    stalled;
  logic [4*OW-1:0] held;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int vexp(input tile_t t, input int i, input int k);
    int s;
    s = 0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        s += bt[i*4+a] * int'($signed(t[a*4+b])) * bt[k*4+b];
      end
    end
`ifdef WINO_IN_TF_SAT_EN
    if (s > (1 << (DW-1)) - 1) s = (1 << (DW-1)) - 1;
    else if (s < -(1 << (DW-1))) s = -(1 << (DW-1));
`endif
    return s;
  endfunction

  function automatic logic [4*DW-1:0] col_of(input tile_t t, input int j);
    logic [4*DW-1:0] c;
    for (int i = 0; i < 4; i++) c[i*DW +: DW] = t[i*4+j];
    return c;
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    int r;
    for (int x = 0; x < 16; x++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      t[x] = 8'sd127;
      else if (r == 1) t[x] = -8'sd128;
      else             t[x] = DW'($urandom);
    end
    return t;
  endfunction

  task automatic set_col(input int vi, input int k, input int a0, input int a1,
                         input int a2, input int a3);
    vecs[vi].v[0*4+k] = OW'(a0);
    vecs[vi].v[1*4+k] = OW'(a1);
    vecs[vi].v[2*4+k] = OW'(a2);
    vecs[vi].v[3*4+k] = OW'(a3);
  endtask

  // One clock of streaming: drive, sample on the falling edge, update model
  task automatic step(input bit vld, input bit rdy);
    int a;
    bus.in_valid  = vld && (src_q.size() > 0);
    bus.in_col    = (src_q.size() > 0) ? col_of(src_q[0], wcol) : '0;
    bus.out_ready = rdy;
    @(negedge clk);
    if (bus.out_valid) begin
      if (stalled) chk("stall_stable", bus.out_col, held);
      if (rdy) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          for (int i = 0; i < 4; i++) begin
            a = $signed(bus.out_col[i*OW +: OW]);
            chk("stream_lane", a, vexp(exp_q[0], i, rk));
          end
          chk("stream_last", bus.out_last, (rk == 3) ? 1 : 0);
          rk++;
          if (rk == 4) begin
            rk = 0;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        stalled = 1'b1;
        held    = bus.out_col;
      end
    end else begin
      stalled = 1'b0;
    end
    if (bus.in_valid && bus.in_ready) begin
      acc_cnt++;
      wcol++;
      if (wcol == 4) begin
        wcol = 0;
        exp_q.push_back(src_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int pv, input int pr, input int budget, output int n);
    n = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step($urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr);
      n++;
    end
    chk("drain_done", src_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int a;
    int base;

    bt = '{1, 0, -1, 0,   0, 1, 1, 0,   0, -1, 1, 0,   0, 1, 0, -1};
    wcol = 0; rk = 0; acc_cnt = 0; stalled = 1'b0; held = '0;

    // Hand-computed vector table
    for (int v = 0; v < 3; v++) vecs[v] = '0;
    for (int x = 0; x < 16; x++) vecs[0].d[x] = 8'sd1;
    vecs[0].v[1*4+1] = 10'sd4;
    vecs[0].sat      = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) vecs[1].d[i*4+j] = DW'(4*i + j);
    set_col(1, 0,   0, -4, 0,   0);
    set_col(1, 1, -16, 30, 8, -16);
    set_col(1, 2,   0,  2, 0,   0);
    set_col(1, 3,   0, -4, 0,   0);
    vecs[1].sat = 1'b0;
    vecs[2].d[0*4+1] = 8'sd127;
    vecs[2].d[0*4+2] = 8'sd127;
    vecs[2].d[2*4+1] = -8'sd128;
    vecs[2].d[2*4+2] = -8'sd128;
`ifdef WINO_IN_TF_SAT_EN
    set_col(2, 0, -128,  127,  127, 0);
    set_col(2, 1,  127, -128, -128, 0);
    set_col(2, 2,    0,    0,    0, 0);
    set_col(2, 3,  127, -128, -128, 0);
    vecs[2].sat = 1'b1;
`else
    set_col(2, 0, -255,  128,  128, 0);
    set_col(2, 1,  510, -256, -256, 0);
    set_col(2, 2,    0,    0,    0, 0);
    set_col(2, 3,  255, -128, -128, 0);
    vecs[2].sat = 1'b0;
`endif

    // Reset
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_col = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_col", bus.out_col, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_sat_flag", sat_flag, 0);

    // Table vectors: 4 columns in, then 4 columns out with no gap
    for (int v = 0; v < 3; v++) begin
      bus.out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
        bus.in_valid = 1'b1;
        bus.in_col   = col_of(vecs[v].d, j);
        @(negedge clk);
        chk("vec_in_ready", bus.in_ready, 1);
        chk("vec_idle_valid", bus.out_valid, 0);
        chk("vec_idle_col", bus.out_col, 0);
        @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b0;
      bus.in_col   = '0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("vec_out_valid", bus.out_valid, 1);
        for (int i = 0; i < 4; i++) begin
          a = $signed(bus.out_col[i*OW +: OW]);
          chk("vec_lane", a, $signed(vecs[v].v[i*4+k]));
        end
        chk("vec_last", bus.out_last, (k == 3) ? 1 : 0);
        @(posedge clk);
        #1;
      end
      chk("vec_sat_flag", sat_flag, vecs[v].sat);
    end

    // Backpressure: three tiles offered, consumer stalled
    for (int t = 0; t < 3; t++) src_q.push_back(rand_tile());
    base = acc_cnt;
    repeat (12) step(1'b1, 1'b0);
    chk("bp_cols_accepted", acc_cnt - base, 8);
    chk("bp_in_ready_low", bus.in_ready, 0);
    drain(100, 100, 100, n);

    // Throughput: continuous input and output, no bubbles
    for (int t = 0; t < 3; t++) src_q.push_back(rand_tile());
    drain(100, 100, 100, n);
    chk("throughput_cycles", n, 16);

    // Random handshake toggling over many tiles
    for (int t = 0; t < 1000; t++) src_q.push_back(rand_tile());
    drain(60, 60, 40000, n);

    // Reset with one unread full tile and a partial tile in flight
    src_q.push_back(rand_tile());
    src_q.push_back(rand_tile());
    repeat (6) step(1'b1, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    src_q.delete(); exp_q.delete();
    wcol = 0; rk = 0; stalled = 1'b0;
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_col", bus.out_col, 0);
    chk("mid_rst_out_last", bus.out_last, 0);
    chk("mid_rst_sat_flag", sat_flag, 0);
    src_q.push_back(rand_tile());
    drain(100, 100, 50, n);
    repeat (6) step(1'b0, 1'b1);
    chk("mid_rst_no_extra", bus.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
